// File: rtl/flash_field_displayer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : flash_field_displayer                                        |
// | Description : Converts FIELD_CNT binary fields to registered 7-segment     |
// |               digits with per-field flashing, global alarm flashing and    |
// |               overflow dashes. Flash pacing comes from a prescaler.        |
// |               Optional feature macro: SCAN_MODE_EN (multiplexed scan out). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module flash_field_displayer #(
  parameter int FIELD_CNT = 3,
  parameter int BIN_WIDTH = 8,
  parameter int BCD_CNT   = 2,
  parameter int FLASH_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alarming,
  input  logic [FIELD_CNT-1:0]           field_flash,
  input  logic [FIELD_CNT*BIN_WIDTH-1:0] cur_value,
  output logic [FIELD_CNT*BCD_CNT*7-1:0] digits,
  output logic [6:0]                     seg_scan,
  output logic [FIELD_CNT*BCD_CNT-1:0]   dig_sel
);

  localparam int CNT_W = $clog2(FLASH_DIV);

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Power of ten as a wide constant; used for digit extraction and overflow.
  function automatic logic [63:0] pow10(input int e);
    logic [63:0] p;
    p = 64'd1;
    for (int n = 0; n < e; n++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Standard active-high segment patterns, bit0=a .. bit6=g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Dividers below 2 are unsupported; this block is intentionally empty and
  // only ties the divider parameters into elaboration.
  if (FLASH_DIV < 2 || SCAN_DIV < 2) begin : g_bad_div_params
  end

  logic [CNT_W-1:0]               r_cnt;
  logic                           r_phase;
  logic                           r_any_flash_d;
  logic                           w_any_flash;
  logic                           w_flash_start;
  logic [FIELD_CNT*BCD_CNT*7-1:0] w_digits_next;

  assign w_any_flash   = alarming | (|field_flash);
  assign w_flash_start = w_any_flash & ~r_any_flash_d;

  // Flash prescaler: free-running half-period counter, restarted into a blank
  // half-period whenever flashing begins so the first blink is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_phase       <= 1'b1;
      r_any_flash_d <= 1'b0;
    end else begin
      r_any_flash_d <= w_any_flash;
      if (w_flash_start) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (r_cnt == CNT_W'(FLASH_DIV - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Per-field combinational conversion with visibility and overflow handling.
  for (genvar i = 0; i < FIELD_CNT; i++) begin : g_field
    localparam logic [63:0] LIMIT = pow10(BCD_CNT);

    logic [BIN_WIDTH-1:0] w_val;
    logic                 w_visible;
    logic                 w_ovf;

    assign w_val     = cur_value[i*BIN_WIDTH +: BIN_WIDTH];
    assign w_visible = r_phase | ~(field_flash[i] | alarming);
    assign w_ovf     = (64'(w_val) >= LIMIT);

    for (genvar j = 0; j < BCD_CNT; j++) begin : g_digit
      localparam logic [63:0] PW = pow10(j);

      logic [3:0] w_bcd;
      logic [6:0] w_seg;

      assign w_bcd = 4'((64'(w_val) / PW) % 64'd10);
      assign w_seg = seg7(w_bcd);
      assign w_digits_next[(i*BCD_CNT+j)*7 +: 7] =
        !w_visible ? SEG_BLANK : (w_ovf ? SEG_DASH : w_seg);
    end
  end

  // Static digit outputs, one clock after their inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
    end else begin
      digits <= w_digits_next;
    end
  end

`ifdef SCAN_MODE_EN
  localparam int NDIG = FIELD_CNT * BCD_CNT;
  localparam int K_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SD_W = $clog2(SCAN_DIV);

  logic [SD_W-1:0] r_scan_cnt;
  logic [K_W-1:0]  r_k;

  // Scan pacing: advance the digit index every SCAN_DIV clocks, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_k        <= '0;
    end else if (r_scan_cnt == SD_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_k        <= (r_k == K_W'(NDIG - 1)) ? '0 : r_k + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Select and segments are taken from the same next-state slice so the scan
  // output is always identical to the static digit it selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel  <= '0;
      seg_scan <= '0;
    end else begin
      dig_sel  <= {{(NDIG-1){1'b0}}, 1'b1} << r_k;
      seg_scan <= w_digits_next[int'(r_k)*7 +: 7];
    end
  end
`else
  assign seg_scan = '0;
  assign dig_sel  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flash_field_displayer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_flash_field_displayer                                     |
// | Description : Directed self-checking bench for flash_field_displayer with  |
// |               FLASH_DIV=4 and fields {23,59,07}. Scan checks enabled when  |
// |               SCAN_MODE_EN is defined.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_flash_field_displayer;

  localparam int FIELD_CNT = 3;
  localparam int BIN_WIDTH = 8;
  localparam int BCD_CNT   = 2;
  localparam int FLASH_DIV = 4;
  localparam int SCAN_DIV  = 2;

  // Field order in the concatenation: {f2d1, f2d0, f1d1, f1d0, f0d1, f0d0}
  localparam logic [41:0] ALL      = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h3F, 7'h07};
  localparam logic [41:0] BLANK1   = {7'h5B, 7'h4F, 7'h00, 7'h00, 7'h3F, 7'h07};
  localparam logic [41:0] BLANKALL = 42'd0;
  localparam logic [41:0] DASH0    = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h40, 7'h40};
  localparam logic [41:0] DASH0_B  = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h00, 7'h00};
  localparam logic [41:0] NINES0   = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6F, 7'h6F};
  localparam logic [41:0] ZERO0    = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h3F, 7'h3F};
  localparam logic [23:0] VAL_BASE = {8'd23, 8'd59, 8'd7};

  logic        clk;
  logic        rst_n;
  logic        alarming;
  logic [2:0]  field_flash;
  logic [23:0] cur_value;
  logic [41:0] digits;
  logic [6:0]  seg_scan;
  logic [5:0]  dig_sel;

  int n_vec;
  int n_err;

  flash_field_displayer #(
    .FIELD_CNT (FIELD_CNT),
    .BIN_WIDTH (BIN_WIDTH),
    .BCD_CNT   (BCD_CNT),
    .FLASH_DIV (FLASH_DIV),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alarming    (alarming),
    .field_flash (field_flash),
    .cur_value   (cur_value),
    .digits      (digits),
    .seg_scan    (seg_scan),
    .dig_sel     (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    alarming    = 1'b0;
    field_flash = 3'b000;
    cur_value   = VAL_BASE;
    tick();
    tick();
    n_vec++;
    if (digits !== BLANKALL) begin
      n_err++;
      $display("FAIL reset_digits: got %h expected %h", digits, BLANKALL);
    end
    n_vec++;
    if (seg_scan !== 7'h00 || dig_sel !== 6'b0) begin
      n_err++;
      $display("FAIL reset_scan: got seg=%h sel=%b expected 00/000000", seg_scan, dig_sel);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (digits !== ALL) begin
      n_err++;
      $display("FAIL release_first_edge: got %h expected %h", digits, ALL);
    end
  endtask

  task automatic test_steady();
    for (int c = 0; c < 100; c++) begin
      tick();
      n_vec++;
      if (digits !== ALL) begin
        n_err++;
        $display("FAIL steady[%0d]: got %h expected %h", c, digits, ALL);
      end
    end
  endtask

  task automatic test_field_flash();
    logic [41:0] exp;
    field_flash = 3'b010;
    tick();  // edge T: flash start sampled
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp = (((c - 1) / 4) % 2 == 0) ? BLANK1 : ALL;
      n_vec++;
      if (digits !== exp) begin
        n_err++;
        $display("FAIL field_flash[T+%0d]: got %h expected %h", c, digits, exp);
      end
    end
    field_flash = 3'b000;
    tick();
    n_vec++;
    if (digits !== ALL) begin
      n_err++;
      $display("FAIL field_flash_off: got %h expected %h", digits, ALL);
    end
  endtask

  task automatic test_alarm();
    logic [41:0] exp;
    alarming = 1'b1;
    tick();  // edge T
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp = (((c - 1) / 4) % 2 == 0) ? BLANKALL : ALL;
      n_vec++;
      if (digits !== exp) begin
        n_err++;
        $display("FAIL alarm[T+%0d]: got %h expected %h", c, digits, exp);
      end
      if (c == 6) field_flash = 3'b001;
    end
    alarming    = 1'b0;
    field_flash = 3'b000;
    tick();
    n_vec++;
    if (digits !== ALL) begin
      n_err++;
      $display("FAIL alarm_off: got %h expected %h", digits, ALL);
    end
  endtask

  task automatic test_overflow();
    logic [41:0] exp;
    cur_value = {8'd23, 8'd59, 8'd100};
    tick();
    n_vec++;
    if (digits !== DASH0) begin
      n_err++;
      $display("FAIL ovf_100: got %h expected %h", digits, DASH0);
    end
    cur_value = {8'd23, 8'd59, 8'd255};
    tick();
    n_vec++;
    if (digits !== DASH0) begin
      n_err++;
      $display("FAIL ovf_255: got %h expected %h", digits, DASH0);
    end
    cur_value = {8'd23, 8'd59, 8'd99};
    tick();
    n_vec++;
    if (digits !== NINES0) begin
      n_err++;
      $display("FAIL val_99: got %h expected %h", digits, NINES0);
    end
    cur_value = {8'd23, 8'd59, 8'd0};
    tick();
    n_vec++;
    if (digits !== ZERO0) begin
      n_err++;
      $display("FAIL val_0: got %h expected %h", digits, ZERO0);
    end
    // Overflowed field still blinks
    cur_value   = {8'd23, 8'd59, 8'd100};
    field_flash = 3'b001;
    tick();  // edge T
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c <= 4) ? DASH0_B : DASH0;
      n_vec++;
      if (digits !== exp) begin
        n_err++;
        $display("FAIL ovf_flash[T+%0d]: got %h expected %h", c, digits, exp);
      end
    end
    field_flash = 3'b000;
    cur_value   = VAL_BASE;
    tick();
  endtask

  task automatic test_reset_mid_flash();
    field_flash = 3'b010;
    tick();  // edge T
    tick();  // T+1, field1 blank
    n_vec++;
    if (digits !== BLANK1) begin
      n_err++;
      $display("FAIL pre_reset_blank: got %h expected %h", digits, BLANK1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (digits !== BLANKALL) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", digits, BLANKALL);
    end
    field_flash = 3'b000;
    tick();
    n_vec++;
    if (digits !== BLANKALL) begin
      n_err++;
      $display("FAIL held_reset: got %h expected %h", digits, BLANKALL);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_vec++;
      if (digits !== ALL) begin
        n_err++;
        $display("FAIL after_reset[%0d]: got %h expected %h", c, digits, ALL);
      end
    end
  endtask

  task automatic test_scan();
    logic [41:0] all_v;
    logic [5:0]  exp_sel;
    logic [6:0]  exp_seg;
    int          k;
    all_v = ALL;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
`ifdef SCAN_MODE_EN
      k       = ((e - 1) / SCAN_DIV) % 6;
      exp_sel = 6'b000001 << k;
      exp_seg = all_v[k*7 +: 7];
`else
      k       = 0;
      exp_sel = 6'b0;
      exp_seg = 7'h00;
`endif
      n_vec++;
      if (dig_sel !== exp_sel) begin
        n_err++;
        $display("FAIL scan_sel[%0d] k=%0d: got %b expected %b", e, k, dig_sel, exp_sel);
      end
      n_vec++;
      if (seg_scan !== exp_seg) begin
        n_err++;
        $display("FAIL scan_seg[%0d] k=%0d: got %h expected %h", e, k, seg_scan, exp_seg);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_steady();
    test_field_flash();
    test_alarm();
    test_overflow();
    test_reset_mid_flash();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
